// File: rtl/gate_truth_table_sweeper.sv
// gate_truth_table_sweeper: drives one 2-input gate through all input vectors and
// checks gate_y against the truth table of the selected function.
module gate_truth_table_sweeper #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       fail_valid,
    output logic [1:0] first_fail
);
    typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;
    // one nibble per op (op 7 in the top nibble), bit index = {a,b}
    localparam logic [31:0] TT = 32'hC9617E83;
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
    state_t state_q;
    logic [2:0] op_q, err_q, err_d;
    logic [1:0] vec_q, vec_d, ff_q;
    logic [3:0] cnt_q;
    logic a_q, b_q, busy_q, done_q, pass_q, fv_q;
    logic single, last, mis;
    always_comb begin
        single = (op_q == 3'd0) || (op_q == 3'd7);
        last   = vec_q == (single ? 2'b10 : 2'b11);
        mis    = gate_y != TT[{op_q, vec_q}];
        err_d  = err_q + {2'b00, mis};
        vec_d  = vec_q + (single ? 2'd2 : 2'd1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= HOLD;
                    op_q    <= op;
                    vec_q   <= '0;
                    cnt_q   <= RELOAD;
                    err_q   <= '0;
                    fv_q    <= 1'b0;
                    pass_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                end
                HOLD: if (cnt_q == 4'd0) begin
                    err_q <= err_d;
                    if (mis && !fv_q) begin
                        ff_q <= vec_q;
                        fv_q <= 1'b1;
                    end
                    if (last) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_d == 3'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                    end else begin
                        vec_q      <= vec_d;
                        {a_q, b_q} <= vec_d;
                        cnt_q      <= RELOAD;
                    end
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gate_a     = a_q;
    assign gate_b     = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;
endmodule

// File: tb/tb_gate_truth_table_sweeper.sv
// tb_gate_truth_table_sweeper: random sweeps against a behavioural gate model, with
// expected sweep results queued at start and checked by a monitor at each done pulse.
module tb_gate_truth_table_sweeper;
    localparam int SETTLE = 2;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [2:0] op = '0;
    logic gate_a, gate_b, gate_y, busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail;
    logic [3:0] gt = '0;
    int n_checks = 0, n_fail = 0;
    typedef struct {
        int n;
        logic [7:0] vecs;
        int err;
        bit fv;
        logic [1:0] ff;
        bit pass;
    } exp_t;
    exp_t exp_q[$];

    gate_truth_table_sweeper #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail(first_fail)
    );

    always #5 clk = ~clk;
    // the gate under test: an arbitrary truth table indexed by {a,b}
    assign gate_y = gt[{gate_a, gate_b}];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic bit ref_fn(input logic [2:0] f, input bit a, input bit b);
        case (f)
            3'd0: return !a;
            3'd1: return a && b;
            3'd2: return a || b;
            3'd3: return !(a && b);
            3'd4: return !(a || b);
            3'd5: return a != b;
            3'd6: return a == b;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] correct(input logic [2:0] f);
        logic [3:0] t;
        for (int v = 0; v < 4; v++) t[v] = ref_fn(f, v[1], v[0]);
        return t;
    endfunction

    function automatic exp_t model(input logic [2:0] f, input logic [3:0] g);
        exp_t e;
        e.n = (f == 3'd0 || f == 3'd7) ? 2 : 4;
        e.vecs = '0;
        e.err = 0;
        e.fv = 1'b0;
        e.ff = '0;
        for (int i = 0; i < e.n; i++) begin
            bit a, b;
            a = (e.n == 2) ? i[0] : i[1];
            b = (e.n == 2) ? 1'b0 : i[0];
            e.vecs[2*i +: 2] = {a, b};
            if (g[{a, b}] != ref_fn(f, a, b)) begin
                if (!e.fv) begin
                    e.ff = {a, b};
                    e.fv = 1'b1;
                end
                e.err++;
            end
        end
        e.pass = e.err == 0;
        return e;
    endfunction

    initial begin : monitor
        logic [1:0] seen[$];
        bit prev_busy;
        bit ok;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen.delete();
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    check("start_err_clear", err_count, 0);
                    check("start_fv_clear", fail_valid, 0);
                    check("start_pass_clear", pass, 0);
                end
                if (prev_busy && !busy) check("done_at_busy_fall", done, 1);
                if (busy) seen.push_back({gate_a, gate_b});
                if (done) begin
                    check("done_busy_low", busy, 0);
                    check("done_gates_low", {gate_a, gate_b}, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        ok = seen.size() == e.n * SETTLE;
                        for (int i = 0; i < seen.size(); i++)
                            if (ok && seen[i] != e.vecs[2*(i/SETTLE) +: 2]) ok = 1'b0;
                        check("vector_sequence", ok, 1);
                        check("err_count", err_count, e.err);
                        check("fail_valid", fail_valid, e.fv);
                        if (e.fv) check("first_fail", first_fail, e.ff);
                        check("pass", pass, e.pass);
                    end
                    seen.delete();
                end
                prev_busy = busy;
            end
        end
    end

    task automatic run_sweep(input logic [2:0] f, input logic [3:0] g, input bit extra);
        bit got;
        got = 1'b0;
        @(negedge clk);
        op = f;
        gt = g;
        start = 1'b1;
        exp_q.push_back(model(f, g));
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                start = extra ? 1'($urandom_range(0, 1)) : 1'b0;
                op = 3'($urandom);
            end
        end
        start = 1'b0;
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic check_zero(input string name);
        check(name, {gate_a, gate_b, busy, done, pass, err_count, fail_valid, first_fail}, 0);
    endtask

    task automatic reset_mid(input logic [2:0] f, input logic [3:0] g);
        exp_t e;
        bit got;
        got = 1'b0;
        @(negedge clk);
        op = f;
        gt = g;
        start = 1'b1;
        exp_q.push_back(model(f, g));
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && {gate_a, gate_b} == 2'b10) got = 1'b1;
        end
        if (!got) check("reach_vec10_timeout", 0, 1);
        #2 rst = 1'b1;
        #1 check_zero("mid_reset_outputs");
        e = exp_q.pop_back();
        repeat (3) @(negedge clk);
        check_zero("mid_reset_held");
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [2:0] f;
        #1 rst = 1'b1;
        #1 check_zero("reset_outputs");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        run_sweep(3'd0, 4'b0011, 1'b0);
        repeat (2) @(negedge clk);
        run_sweep(3'd3, 4'b0110, 1'b0);
        run_sweep(3'd4, 4'b1111, 1'b0);
        run_sweep(3'd1, 4'b0000, 1'b1);
        reset_mid(3'd5, 4'($urandom));
        run_sweep(3'd5, correct(3'd5), 1'b0);
        run_sweep(3'd6, 4'($urandom), 1'b0);
        run_sweep(3'd2, 4'($urandom), 1'b0);
        for (int s = 0; s < 30; s++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            f = 3'($urandom);
            run_sweep(f, ($urandom_range(0, 2) == 0) ? correct(f) : 4'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_truth_table_sweeper.md
Name: gate_truth_table_sweeper

Overview:
Sequencer that exhaustively drives a single combinational gate under test (e.g. a NAND-built inverter) through every input vector. It samples the gate output after a programmable settle time and compares it against the expected truth table for a selected function. It reports the mismatch count, the first failing vector, and pass/fail. It sits between a bench or host controller and one gate instance, replacing hand-written per-vector stimulus.

Parameters:
SETTLE, 2, cycles each vector is held before gate_y is sampled; legal range 1..15.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  begin a sweep. Sampled only in IDLE.
op  input  3  expected function, latched at start: 0 NOT(a), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF(a).
gate_a  output  1  stimulus to gate input a (registered).
gate_b  output  1  stimulus to gate input b (registered).
gate_y  input  1  gate output under test.
busy  output  1  high while sweeping.
done  output  1  one-cycle pulse at sweep end.
pass  output  1  1 when the last sweep had zero mismatches. Held until next start.
err_count  output  3  mismatches in the last sweep (0..4).
fail_valid  output  1  at least one mismatch recorded.
first_fail  output  2  vector {a,b} of the first mismatch. Valid only when fail_valid is high.

Behaviour:
- Reset (async, immediate): state IDLE; gate_a, gate_b, busy, done, pass, err_count, fail_valid, first_fail all 0. Reset mid-sweep aborts with no done pulse.
- States: IDLE, HOLD, FINISH.
- IDLE, start=1 at edge T:
  - latch op; vec=0; settle counter=SETTLE-1; err_count=0, fail_valid=0, pass=0; busy=1.
  - {gate_a,gate_b}=vec from cycle T+1.
  - go to HOLD.
- Vector count N: 2 for op 0 and 7 (b held 0; vec sweeps a=0,1). N=4 otherwise; vec sweeps {a,b}=00,01,10,11 in order.
- HOLD: decrement counter each cycle. At the edge where counter==0, sample gate_y and compare with expected(op, vec):
  - On mismatch: err_count+1. If fail_valid=0, first_fail=vec and fail_valid=1.
  - If vec is the last vector: go to FINISH.
  - Otherwise: advance vec, reload counter=SETTLE-1, drive the new vector on that same edge.
- Each vector is stable for exactly SETTLE cycles. Total busy cycles = N*SETTLE.
- Mismatch accounting includes the final sample. pass in FINISH is computed from the updated count.
- FINISH (one cycle): busy=0, done=1, pass=(err_count==0), gate_a/gate_b return to 0; next state IDLE.
- done is high only in the FINISH cycle.
- start while busy or in FINISH: ignored, no effect.
- start in the cycle immediately after FINISH (IDLE) is accepted normally.
- Results (pass, err_count, fail_valid, first_fail) hold until the next accepted start or reset.
- op changes during a sweep have no effect (latched value used).
- gate_y is treated as synchronous (the gate is purely combinational, driven by registered stimulus). No synchroniser.

Test Plan:
1. op=0, gate_y=~gate_a (NAND-built inverter), SETTLE=2, start pulse → busy for 4 cycles, vectors a=0 then 1, done pulse, pass=1, err_count=0, fail_valid=0.
2. op=3 (NAND), gate_y=gate_a^gate_b → single mismatch at 00 → err_count=1, first_fail=2'b00, pass=0; busy lasts 8 cycles.
3. op=4 (NOR), gate_y stuck at 1 → mismatches at 01, 10, 11 → err_count=3, first_fail=2'b01, fail_valid=1, pass=0.
4. op=1 (AND), gate_y stuck at 0, extra start pulses while busy → exactly one sweep runs; err_count=1, first_fail=2'b11; single done pulse.
5. Reset asserted mid-sweep at vector 10 → all outputs 0 immediately, no done pulse. A new start then yields a clean full sweep with correct results.
6. Back-to-back: start asserted in the cycle after done → second sweep begins, err_count cleared to 0, pass=0 until its FINISH. Results reflect only the second sweep.
